mem_access_unit: RTL and testbench

Memory-stage load/store unit of the RISC-V pipeline: consumes the memory-control and address/data outputs of the EX/ME pipeline register and performs the access on the Avalon-MM data bus toward on-chip memory and the camera/HPS bridge. It generates word-aligned addresses, byte enables and lane-replicated store data. It sign/zero-extends load data and holds the pipeline through a stall output until the bus transaction completes.

---
 rtl/mem_access_unit.sv | 191 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : Memory-stage load/store unit. Turns EX/ME memory-control
//               signals into a single Avalon-MM transaction (word-aligned
//               address, byte enables, lane-replicated store data), extends
//               the returned load data and stalls the pipeline until the
//               access completes.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read_in,
  input  logic                  mem_write_en_in,
  input  logic                  mem_sign_in,
  input  logic [1:0]            mem_length_in,
  input  logic [31:0]           alu_result_in,
  input  logic [31:0]           write_data_in,
  output logic                  stall_out,
  output logic                  misaligned_out,
  output logic [31:0]           load_data_out,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic                  bus_read,
  output logic                  bus_write,
  output logic [3:0]            bus_byteenable,
  output logic [31:0]           bus_writedata,
  input  logic [31:0]           bus_readdata,
  input  logic                  bus_waitrequest,
  input  logic                  bus_readdatavalid
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REQ    = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [1:0] LEN_BYTE = 2'b00;
  localparam logic [1:0] LEN_HALF = 2'b01;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]            be_q, be_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  is_read_q, is_read_d;
  logic                  is_write_q, is_write_d;
  logic [1:0]            length_q, length_d;
  logic                  sign_q, sign_d;
  logic [1:0]            lane_q, lane_d;
  logic [31:0]           load_data_q, load_data_d;

  logic                  any_op;
  logic                  misaligned;
  logic                  req;
  logic [3:0]            be_new;
  logic [31:0]           wdata_new;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic [31:0]           load_ext;

  // Qualify the incoming request: alignment is only judged when an access is asked for
  always_comb begin
    any_op     = mem_read_in | mem_write_en_in;
    misaligned = 1'b0;
    if (mem_length_in == LEN_HALF) begin
      misaligned = alu_result_in[0];
    end else if (mem_length_in[1]) begin
      misaligned = |alu_result_in[1:0];
    end
    misaligned = misaligned & any_op;
    req        = any_op & ~misaligned;
  end

  // Byte enables and lane-replicated store data for the incoming request
  always_comb begin
    be_new    = 4'b1111;
    wdata_new = write_data_in;
    case (mem_length_in)
      LEN_BYTE: begin
        be_new    = 4'b0001 << alu_result_in[1:0];
        wdata_new = {4{write_data_in[7:0]}};
      end
      LEN_HALF: begin
        be_new    = alu_result_in[1] ? 4'b1100 : 4'b0011;
        wdata_new = {2{write_data_in[15:0]}};
      end
      default: begin
        be_new    = 4'b1111;
        wdata_new = write_data_in;
      end
    endcase
  end

  // Select the addressed lane of the read data and extend it to 32 bits
  always_comb begin
    byte_sel = bus_readdata[{lane_q, 3'b000} +: 8];
    half_sel = lane_q[1] ? bus_readdata[31:16] : bus_readdata[15:0];
    case (length_q)
      LEN_BYTE: load_ext = {{24{sign_q & byte_sel[7]}}, byte_sel};
      LEN_HALF: load_ext = {{16{sign_q & half_sel[15]}}, half_sel};
      default:  load_ext = bus_readdata;
    endcase
  end

  // Transaction sequencing; DONE ignores inputs so the held request is not reissued
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    is_read_d   = is_read_q;
    is_write_d  = is_write_q;
    length_d    = length_q;
    sign_d      = sign_q;
    lane_d      = lane_q;
    load_data_d = load_data_q;
    stall_out   = 1'b0;
    case (state_q)
      S_IDLE: begin
        stall_out = req;
        if (req) begin
          state_d    = S_REQ;
          addr_d     = {alu_result_in[ADDR_WIDTH-1:2], 2'b00};
          be_d       = be_new;
          wdata_d    = wdata_new;
          // A simultaneous read and write performs the read only
          is_read_d  = mem_read_in;
          is_write_d = ~mem_read_in;
          length_d   = mem_length_in;
          sign_d     = mem_sign_in;
          lane_d     = alu_result_in[1:0];
        end
      end
      S_REQ: begin
        stall_out = 1'b1;
        if (!bus_waitrequest) begin
          state_d = is_read_q ? S_RESP : S_DONE;
        end
      end
      S_RESP: begin
        stall_out = 1'b1;
        if (bus_readdatavalid) begin
          load_data_d = load_ext;
          state_d     = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and command registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      be_q        <= 4'b0000;
      wdata_q     <= 32'h0;
      is_read_q   <= 1'b0;
      is_write_q  <= 1'b0;
      length_q    <= 2'b00;
      sign_q      <= 1'b0;
      lane_q      <= 2'b00;
      load_data_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      is_read_q   <= is_read_d;
      is_write_q  <= is_write_d;
      length_q    <= length_d;
      sign_q      <= sign_d;
      lane_q      <= lane_d;
      load_data_q <= load_data_d;
    end
  end

  assign misaligned_out = misaligned;
  assign load_data_out  = load_data_q;
  assign bus_addr       = addr_q;
  assign bus_byteenable = be_q;
  assign bus_writedata  = wdata_q;
  assign bus_read       = (state_q == S_REQ) & is_read_q;
  assign bus_write      = (state_q == S_REQ) & is_write_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Self-checking bench for mem_access_unit. Each operation is
//               expanded into its expected cycle-by-cycle timeline from the
//               access rules; a single compare process checks every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read_in, mem_write_en_in, mem_sign_in;
  logic [1:0]  mem_length_in;
  logic [31:0] alu_result_in, write_data_in;
  logic        stall_out, misaligned_out;
  logic [31:0] load_data_out;
  logic [31:0] bus_addr;
  logic        bus_read, bus_write;
  logic [3:0]  bus_byteenable;
  logic [31:0] bus_writedata, bus_readdata;
  logic        bus_waitrequest, bus_readdatavalid;

  mem_access_unit #(.ADDR_WIDTH(32)) dut (
    .clk               (clk),
    .rst               (rst),
    .mem_read_in       (mem_read_in),
    .mem_write_en_in   (mem_write_en_in),
    .mem_sign_in       (mem_sign_in),
    .mem_length_in     (mem_length_in),
    .alu_result_in     (alu_result_in),
    .write_data_in     (write_data_in),
    .stall_out         (stall_out),
    .misaligned_out    (misaligned_out),
    .load_data_out     (load_data_out),
    .bus_addr          (bus_addr),
    .bus_read          (bus_read),
    .bus_write         (bus_write),
    .bus_byteenable    (bus_byteenable),
    .bus_writedata     (bus_writedata),
    .bus_readdata      (bus_readdata),
    .bus_waitrequest   (bus_waitrequest),
    .bus_readdatavalid (bus_readdatavalid)
  );

  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_fail = 0;

  // Expected values for the current cycle
  bit          chk_en   = 1'b0;
  bit          chk_zero = 1'b0;
  bit          exp_stall, exp_mis, exp_rd, exp_wr;
  logic [31:0] exp_addr, exp_wd, exp_ld;
  logic [3:0]  exp_be;

  // Last observed store command, for the hand-computed pins
  logic [31:0] last_w_addr, last_w_wd;
  logic [3:0]  last_w_be;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] extend(input logic [31:0] d, input logic [1:0] len,
                                         input logic [1:0] off, input bit sg);
    logic [31:0] s;
    s = d >> (8 * off);
    if (len == 2'b00) return (sg && s[7])  ? {24'hFFFFFF, s[7:0]}  : {24'h0, s[7:0]};
    if (len == 2'b01) return (sg && s[15]) ? {16'hFFFF, s[15:0]}   : {16'h0, s[15:0]};
    return d;
  endfunction

  // Single compare process: every cycle while checking is enabled
  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall_out",      {31'b0, stall_out},      {31'b0, exp_stall});
      chk("misaligned_out", {31'b0, misaligned_out}, {31'b0, exp_mis});
      chk("bus_read",       {31'b0, bus_read},       {31'b0, exp_rd});
      chk("bus_write",      {31'b0, bus_write},      {31'b0, exp_wr});
      chk("load_data_out",  load_data_out,           exp_ld);
      if (exp_rd || exp_wr) begin
        chk("bus_addr",       bus_addr,                exp_addr);
        chk("bus_byteenable", {28'b0, bus_byteenable}, {28'b0, exp_be});
      end
      if (exp_wr) chk("bus_writedata", bus_writedata, exp_wd);
      if (chk_zero) begin
        chk("rst_bus_addr",   bus_addr,                32'h0);
        chk("rst_byteenable", {28'b0, bus_byteenable}, 32'h0);
        chk("rst_writedata",  bus_writedata,           32'h0);
      end
    end
    if (bus_write) begin
      last_w_addr = bus_addr;
      last_w_be   = bus_byteenable;
      last_w_wd   = bus_writedata;
    end
  end

  // Present one instruction and walk its expected timeline; w = waitrequest
  // cycles in REQ, l = cycles from acceptance to readdatavalid (>=1)
  task automatic run_op(input bit rd, input bit wr, input bit sg, input logic [1:0] len,
                        input logic [31:0] a, input logic [31:0] wdat,
                        input int w, input int l, input logic [31:0] rdat);
    bit mis, isrd, iswr;
    mis  = (rd || wr) && ((len == 2'b01 && a[0]) || (len[1] && a[1:0] != 2'b00));
    isrd = rd && !mis;
    iswr = wr && !rd && !mis;
    mem_read_in = rd; mem_write_en_in = wr; mem_sign_in = sg;
    mem_length_in = len; alu_result_in = a; write_data_in = wdat;
    exp_addr = {a[31:2], 2'b00};
    exp_be   = (len == 2'b00) ? (4'b0001 << a[1:0]) : (len == 2'b01) ? (4'b0011 << a[1:0]) : 4'b1111;
    exp_wd   = (len == 2'b00) ? {4{wdat[7:0]}} : (len == 2'b01) ? {2{wdat[15:0]}} : wdat;
    // IDLE cycle
    exp_mis = mis; exp_rd = 1'b0; exp_wr = 1'b0; exp_stall = isrd || iswr;
    bus_waitrequest = 1'($urandom); bus_readdatavalid = 1'($urandom); bus_readdata = $urandom;
    tick();
    if (!(isrd || iswr)) return;
    // REQ cycles: readdatavalid here must be ignored
    for (int i = 0; i <= w; i++) begin
      exp_rd = isrd; exp_wr = iswr; exp_stall = 1'b1;
      bus_waitrequest = (i < w); bus_readdatavalid = 1'($urandom); bus_readdata = $urandom;
      tick();
    end
    exp_rd = 1'b0; exp_wr = 1'b0;
    // RESP cycles
    if (isrd) begin
      for (int j = 1; j <= l; j++) begin
        exp_stall = 1'b1;
        bus_waitrequest = 1'($urandom);
        bus_readdatavalid = (j == l);
        bus_readdata = (j == l) ? rdat : $urandom;
        tick();
      end
      exp_ld = extend(rdat, len, a[1:0], sg);
    end
    // DONE cycle
    exp_stall = 1'b0;
    bus_waitrequest = 1'($urandom); bus_readdatavalid = 1'($urandom); bus_readdata = $urandom;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    mem_read_in = 0; mem_write_en_in = 0; mem_sign_in = 0; mem_length_in = 0;
    alu_result_in = 0; write_data_in = 0;
    bus_readdata = 0; bus_waitrequest = 0; bus_readdatavalid = 0;
    last_w_addr = 0; last_w_be = 0; last_w_wd = 0;
    exp_addr = 0; exp_be = 0; exp_wd = 0; exp_ld = 0;
    tick(); tick(); tick();

    // Reset state
    rst = 1'b0;
    exp_stall = 0; exp_mis = 0; exp_rd = 0; exp_wr = 0; exp_ld = 32'h0;
    chk_en = 1'b1; chk_zero = 1'b1;
    tick();
    chk_zero = 1'b0;

    // Store byte at 0x103
    run_op(0, 1, 0, 2'b00, 32'h0000_0103, 32'h0000_00A5, 0, 1, 32'h0);
    chk("pin_sb_addr", last_w_addr, 32'h0000_0100);
    chk("pin_sb_be",   {28'b0, last_w_be}, 32'h8);
    chk("pin_sb_wd",   last_w_wd, 32'hA5A5_A5A5);
    chk("pin_sb_ld",   load_data_out, 32'h0);

    // Signed half load at 0x202, 2 wait cycles, data 3 cycles after accept
    run_op(1, 0, 1, 2'b01, 32'h0000_0202, 32'h0, 2, 3, 32'h8001_1234);
    chk("pin_lh_signed", load_data_out, 32'hFFFF_8001);

    // Byte loads at 0x1, unsigned then signed
    run_op(1, 0, 0, 2'b00, 32'h0000_0001, 32'h0, 0, 1, 32'h0000_F300);
    chk("pin_lbu", load_data_out, 32'h0000_00F3);
    run_op(1, 0, 1, 2'b00, 32'h0000_0001, 32'h0, 1, 2, 32'h0000_F300);
    chk("pin_lb", load_data_out, 32'hFFFF_FFF3);

    // Misaligned word load at 0x6
    run_op(1, 0, 0, 2'b10, 32'h0000_0006, 32'h0, 0, 1, 32'h1234_5678);

    // Load then store back to back; then simultaneous read+write
    run_op(1, 0, 0, 2'b10, 32'h0000_0040, 32'h0, 0, 1, 32'hCAFE_F00D);
    run_op(0, 1, 0, 2'b11, 32'h0000_0044, 32'h1357_9BDF, 0, 1, 32'h0);
    run_op(1, 1, 0, 2'b01, 32'h0000_0082, 32'h5555_AAAA, 1, 2, 32'hBEEF_0042);
    chk("pin_rw_read", load_data_out, 32'h0000_BEEF);

    // Reset during RESP abandons the load
    mem_read_in = 1; mem_write_en_in = 0; mem_sign_in = 0; mem_length_in = 2'b10;
    alu_result_in = 32'h0000_0300; write_data_in = 0;
    exp_addr = 32'h0000_0300; exp_be = 4'hF; exp_mis = 0;
    exp_stall = 1; exp_rd = 0; exp_wr = 0; bus_waitrequest = 0; bus_readdatavalid = 0;
    tick();                                   // IDLE
    exp_rd = 1;
    tick();                                   // REQ, accepted
    exp_rd = 0; rst = 1'b1;
    tick();                                   // RESP, reset sampled at the next edge
    rst = 1'b0; mem_read_in = 0;
    exp_stall = 0; exp_ld = 32'h0; chk_zero = 1'b1;
    bus_readdatavalid = 1; bus_readdata = 32'hDEAD_BEEF;
    tick();                                   // IDLE after reset, late data
    tick();
    chk_zero = 1'b0; bus_readdatavalid = 0;
    chk("pin_rst_ld", load_data_out, 32'h0);

    // Randomized operations
    for (int n = 0; n < 400; n++) begin
      int          k;
      bit          rd, wr;
      logic [1:0]  len;
      logic [31:0] a;
      k   = $urandom_range(0, 9);
      rd  = (k == 1) || (k >= 2 && k <= 5);
      wr  = (k == 1) || (k >= 6);
      len = 2'($urandom);
      a   = $urandom;
      if ($urandom_range(0, 9) < 7) begin
        if (len == 2'b01) a[0] = 1'b0;
        else if (len[1]) a[1:0] = 2'b00;
      end
      run_op(rd, wr, 1'($urandom), len, a, $urandom,
             $urandom_range(0, 3), $urandom_range(1, 4), $urandom);
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
